afe_spi_arbiter: RTL and testbench
==================================

AFE_SPI_ARBITER -- requirements
Module: afe_spi_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters and chip selects; range 2..8.
REQ-002 Parameter CLK_DIV, default 4: SPI clock half-period in sysClk cycles; minimum 2.
REQ-003 Parameter DW, default 32: maximum transfer length in bits.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 sysClk, input, 1: sole clock.
REQ-006 sysReset_n, input, 1: asynchronous active-low reset.
REQ-007 req, input, N_REQ: per-requester transfer request, level.
REQ-008 wdata, input, N_REQ*DW: per-requester write word, right-justified.
REQ-009 bitCount, input, N_REQ*6: per-requester transfer length; legal range 1..DW.
REQ-010 grant, output, N_REQ: one-hot owner of the active transfer.
REQ-011 done, output, 1: single-cycle end-of-transfer pulse.
REQ-012 rdata, output, DW: captured SDO word, right-justified.
REQ-013 busy, output, 1: transfer in progress.
REQ-014 spiClk, output, 1; spiSdi, output, 1; spiSdo, input, 1; spiCsb, output, N_REQ, active-low selects.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-016 In IDLE with any req high, the block SHALL latch the round-robin winner, its wdata and its bitCount, then enter SETUP on the next edge; grant, busy and spiCsb[winner] low SHALL be asserted on that same edge.
REQ-017 Round-robin rule: search starts at the index after the last winner, wrapping from N_REQ-1 to 0; after reset the search starts at index 0.
REQ-018 SETUP SHALL last CLK_DIV cycles, with spiClk=0 and spiSdi driving the MSB (bit bitCount-1).
REQ-019 SHIFT SHALL emit bitCount SPI clocks (mode 0, MSB first): CLK_DIV cycles low, then CLK_DIV cycles high per bit.
REQ-020 spiSdo SHALL be sampled on the sysClk edge that raises spiClk, and spiSdi SHALL advance on the edge that lowers it.
REQ-021 HOLD SHALL last CLK_DIV cycles with spiClk=0 and chip select still asserted.
REQ-022 On leaving HOLD, the block SHALL deassert spiCsb, pulse done for one cycle with grant still valid, update rdata with the upper DW-bitCount bits set to 0, and enter GAP.
REQ-023 GAP SHALL last CLK_DIV cycles with all selects high, then clear grant and busy and return to IDLE.
REQ-024 Total chip-select-low time SHALL be CLK_DIV*(2*bitCount+2) cycles.
REQ-025 A req deasserted mid-transfer SHALL NOT abort the transfer.
REQ-026 A req still high in IDLE after its done SHALL be serviced only if no other requester is pending.
REQ-027 bitCount of 0 or greater than DW SHALL be clamped to DW.
REQ-028 Simultaneous requests SHALL be resolved by REQ-017 only; the transfer in progress is never preempted.
REQ-029 At most one spiCsb bit SHALL be low in any cycle.

Reset
REQ-030 Asserting sysReset_n low SHALL, at any state including mid-transfer, immediately force: spiCsb all 1, spiClk 0, spiSdi 0, grant 0, done 0, busy 0, rdata 0, FSM to IDLE, round-robin pointer to 0.
REQ-031 After reset release, the first transfer SHALL follow REQ-016 with no extra wait.

Structure
REQ-032 FSM state encoding and the bitCount field width (6) SHALL reside in the shared package dsbpm_spi_pkg.
REQ-033 Round-robin selection SHALL be a sub-module, rr_arbiter (inputs: request vector, last-winner index; output: one-hot winner).

Verification
REQ-034 Reset, then req=0001, bitCount=8, wdata=0xA5, CLK_DIV=2 -> spiSdi bits 1,0,1,0,0,1,0,1; 8 spiClk pulses; spiCsb[0] low for 36 cycles; one done pulse.
REQ-035 spiSdo driven with 0x3C during an 8-bit transfer -> rdata=0x0000003C at done.
REQ-036 req=1111 held continuously -> grant order 0,1,2,3,0, with every transfer separated by at least CLK_DIV cycles of all selects high.
REQ-037 Reset asserted in the middle of bit 5 of a 24-bit transfer -> all outputs take their reset values that cycle; after release with req=0100, grant=0100 comes first.
REQ-038 bitCount=0 and bitCount=40 with DW=32 -> 32 spiClk pulses each.
REQ-039 req[1] dropped during SHIFT -> the transfer completes and done is pulsed; no new transfer starts for requester 1.

Source files
------------

// File: rtl/dsbpm_spi_pkg.sv
// Shared definitions for the AFE SPI arbiter: FSM encoding, bitCount field width,
// and the transfer-length clamp.
package dsbpm_spi_pkg;

    localparam int BC_W = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Zero or over-length requests fall back to a full-width transfer.
    function automatic logic [BC_W-1:0] clamp_len(input logic [BC_W-1:0] bc, input int dw);
        if (bc == '0 || int'(bc) > dw) begin
            return BC_W'(dw);
        end
        return bc;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester after last_i, wrapping at N_REQ-1.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req_i[i] && (i == (int'(last_i) + k) % N_REQ)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/afe_spi_arbiter.sv
// Shares one mode-0 SPI master between N_REQ requesters, one chip select each.
//   state | meaning
//   IDLE  | waiting for any req; latches winner, data and length
//   SETUP | select low, spiClk low, MSB on spiSdi
//   SHIFT | bitCount clocks, CLK_DIV low then CLK_DIV high per bit
//   HOLD  | select still low, spiClk low after last bit
//   GAP   | all selects high; done pulses on entry
module afe_spi_arbiter
    import dsbpm_spi_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CLK_DIV = 4,
    parameter int DW      = 32
) (
    input  logic                  sysClk,
    input  logic                  sysReset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   wdata,
    input  logic [N_REQ*BC_W-1:0] bitCount,
    output logic [N_REQ-1:0]      grant,
    output logic                  done,
    output logic [DW-1:0]         rdata,
    output logic                  busy,
    output logic                  spiClk,
    output logic                  spiSdi,
    input  logic                  spiSdo,
    output logic [N_REQ-1:0]      spiCsb
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TW    = $clog2(CLK_DIV);
    localparam logic [TW-1:0] T_LOAD = TW'(CLK_DIV - 1);

    spi_state_e       state_q;
    logic [TW-1:0]    timer_q;
    logic [BC_W-1:0]  bits_q;
    logic [DW-1:0]    tx_q, rx_q, rdata_q;
    logic [IDX_W-1:0] ptr_q;
    logic [N_REQ-1:0] grant_q, csb_q;
    logic             busy_q, done_q, sclk_q;

    logic [N_REQ-1:0] win_d;
    logic [IDX_W-1:0] win_idx_d, last_idx_d, ptr_d;
    logic [DW-1:0]    wsel_d, tx_load_d;
    logic [BC_W-1:0]  len_d;

    // ptr_q is the next search start; the arbiter wants the index just before it.
    assign last_idx_d = (ptr_q == '0) ? IDX_W'(N_REQ - 1) : ptr_q - IDX_W'(1);

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i  (req),
        .last_i (last_idx_d),
        .gnt_o  (win_d)
    );

    always_comb begin
        win_idx_d = '0;
        wsel_d    = '0;
        len_d     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_d[i]) begin
                win_idx_d = IDX_W'(i);
                wsel_d    = wdata[i*DW +: DW];
                len_d     = clamp_len(bitCount[i*BC_W +: BC_W], DW);
            end
        end
        // Left-align so the transfer MSB always sits at tx_q[DW-1].
        tx_load_d = wsel_d << (BC_W'(DW) - len_d);
        ptr_d     = (win_idx_d == IDX_W'(N_REQ - 1)) ? '0 : win_idx_d + IDX_W'(1);
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            csb_q   <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_d != '0) begin
                        grant_q <= win_d;
                        csb_q   <= ~win_d;
                        busy_q  <= 1'b1;
                        tx_q    <= tx_load_d;
                        rx_q    <= '0;
                        bits_q  <= len_d;
                        ptr_q   <= ptr_d;
                        timer_q <= T_LOAD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_q == '0) begin
                        timer_q <= T_LOAD;
                        state_q <= SHIFT;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                SHIFT: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - TW'(1);
                    end else begin
                        timer_q <= T_LOAD;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            rx_q   <= {rx_q[DW-2:0], spiSdo};
                        end else begin
                            sclk_q <= 1'b0;
                            if (bits_q == BC_W'(1)) begin
                                tx_q    <= '0;
                                state_q <= HOLD;
                            end else begin
                                bits_q <= bits_q - BC_W'(1);
                                tx_q   <= {tx_q[DW-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        csb_q   <= '1;
                        done_q  <= 1'b1;
                        rdata_q <= rx_q;
                        timer_q <= T_LOAD;
                        state_q <= GAP;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                GAP: begin
                    if (timer_q == '0) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign spiClk = sclk_q;
    assign spiSdi = tx_q[DW-1];
    assign spiCsb = csb_q;

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// Bench for afe_spi_arbiter: a bus monitor plus SPI slave, and scenario tasks
// checked against a behavioural model of arbitration and transfer framing.
module tb_afe_spi_arbiter;

    localparam int N_REQ   = 4;
    localparam int DW      = 32;
    localparam int CLK_DIV = 2;
    localparam int BW      = 6;

    logic                 sysClk     = 1'b0;
    logic                 sysReset_n = 1'b1;
    logic [N_REQ-1:0]     req        = '0;
    logic [N_REQ*DW-1:0]  wdata      = '0;
    logic [N_REQ*BW-1:0]  bitCount   = '0;
    logic [N_REQ-1:0]     grant;
    logic                 done;
    logic [DW-1:0]        rdata;
    logic                 busy;
    logic                 spiClk;
    logic                 spiSdi;
    logic                 spiSdo     = 1'b0;
    logic [N_REQ-1:0]     spiCsb;

    int errors  = 0;
    int checks  = 0;
    int rr_last = -1;

    int          clk_rises  = 0;
    int          xfer_rises = 0;
    int          cs_low     = 0;
    int          done_cnt   = 0;
    int          multi_cs   = 0;
    int          gap_run    = 0;
    int          min_gap    = 1000000;
    bit          seen_low   = 1'b0;
    logic        sclk_prev  = 1'b0;
    logic [63:0] sdi_bits   = '0;
    logic [DW-1:0] slave_word = '0;
    int          slave_len  = 8;

    afe_spi_arbiter #(.N_REQ(N_REQ), .CLK_DIV(CLK_DIV), .DW(DW)) dut (
        .sysClk     (sysClk),
        .sysReset_n (sysReset_n),
        .req        (req),
        .wdata      (wdata),
        .bitCount   (bitCount),
        .grant      (grant),
        .done       (done),
        .rdata      (rdata),
        .busy       (busy),
        .spiClk     (spiClk),
        .spiSdi     (spiSdi),
        .spiSdo     (spiSdo),
        .spiCsb     (spiCsb)
    );

    always #5 sysClk = ~sysClk;

    // Bus monitor and mode-0 slave: SDO changes only while spiClk is low.
    always @(negedge sysClk) begin : mon
        int k;
        if (spiClk && !sclk_prev) begin
            clk_rises++;
            xfer_rises++;
            sdi_bits = {sdi_bits[62:0], spiSdi};
        end
        sclk_prev = spiClk;
        if ($countones(~spiCsb) > 1) multi_cs++;
        if (spiCsb == '1) begin
            xfer_rises = 0;
            gap_run++;
        end else begin
            cs_low++;
            if (seen_low && gap_run > 0 && gap_run < min_gap) min_gap = gap_run;
            gap_run  = 0;
            seen_low = 1'b1;
        end
        if (done) done_cnt++;
        if (!spiClk) begin
            k = slave_len - 1 - xfer_rises;
            spiSdo = (k >= 0 && k < DW) ? slave_word[k] : 1'b0;
        end
    end

    function automatic int model_rr(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int model_len(input int bc);
        return (bc == 0 || bc > DW) ? DW : bc;
    endfunction

    function automatic logic [DW-1:0] model_mask(input int len);
        logic [63:0] m;
        m = (64'd1 << len) - 64'd1;
        return m[DW-1:0];
    endfunction

    task automatic launch(input logic [N_REQ-1:0] rv, input bit keep);
        @(negedge sysClk);
        req = rv;
        @(posedge sysClk);
        #1;
        if (!keep) req = '0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge sysClk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge sysClk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        @(negedge sysClk);
        sysReset_n = 1'b0;
        req        = '0;
        repeat (2) @(negedge sysClk);
        sysReset_n = 1'b1;
        rr_last    = -1;
    endtask

    task automatic test_reset;
        #2;
        sysReset_n = 1'b0;
        #1;
        checks++; if (spiCsb !== '1)    begin errors++; $display("FAIL rst_csb: got %b expected 1111", spiCsb); end
        checks++; if (spiClk !== 1'b0)  begin errors++; $display("FAIL rst_sclk: got %b expected 0", spiClk); end
        checks++; if (spiSdi !== 1'b0)  begin errors++; $display("FAIL rst_sdi: got %b expected 0", spiSdi); end
        checks++; if (grant !== '0)     begin errors++; $display("FAIL rst_grant: got %b expected 0000", grant); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rdata !== '0)     begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
        repeat (2) @(negedge sysClk);
        sysReset_n = 1'b1;
        rr_last    = -1;
        repeat (2) @(negedge sysClk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single;
        int base_r, base_cs, base_d;
        bit ok;
        wdata[0*DW +: DW]    = 32'hA5;
        bitCount[0*BW +: BW] = 6'd8;
        slave_word = 32'h3C;
        slave_len  = 8;
        base_r = clk_rises; base_cs = cs_low; base_d = done_cnt;
        launch(4'b0001, 1'b0);
        checks++; if (grant !== 4'b0001)  begin errors++; $display("FAIL single_grant: got %b expected 0001", grant); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        checks++; if (spiCsb !== 4'b1110) begin errors++; $display("FAIL single_csb: got %b expected 1110", spiCsb); end
        checks++; if (spiSdi !== 1'b1)    begin errors++; $display("FAIL single_setup_msb: got %b expected 1", spiSdi); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout: got none expected done"); end
        checks++; if (sdi_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL single_sdi: got %h expected a5", sdi_bits[7:0]); end
        checks++; if (clk_rises - base_r !== 8) begin errors++; $display("FAIL single_sclk: got %0d expected 8", clk_rises - base_r); end
        checks++; if (cs_low - base_cs !== 36)  begin errors++; $display("FAIL single_cs_low: got %0d expected 36", cs_low - base_cs); end
        checks++; if (rdata !== 32'h0000003C)   begin errors++; $display("FAIL single_rdata: got %h expected 0000003c", rdata); end
        checks++; if (grant !== 4'b0001)        begin errors++; $display("FAIL single_grant_at_done: got %b expected 0001", grant); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle_timeout: got busy expected idle"); end
        checks++; if (done_cnt - base_d !== 1)  begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - base_d); end
        rr_last = 0;
    endtask

    task automatic test_back_to_back;
        logic [N_REQ-1:0] got [5];
        int n, w;
        bit ok;
        apply_reset;
        for (int i = 0; i < N_REQ; i++) bitCount[i*BW +: BW] = 6'd4;
        slave_len = 4;
        min_gap   = 1000000;
        seen_low  = 1'b0;
        n = 0;
        @(negedge sysClk);
        req = '1;
        for (int c = 0; c < 2000 && n < 5; c++) begin
            @(negedge sysClk);
            if (done) begin
                got[n] = grant;
                n++;
            end
        end
        req = '0;
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", n); end
        for (int i = 0; i < n; i++) begin
            w = model_rr('1, rr_last);
            checks++;
            if (got[i] !== N_REQ'(1 << w)) begin
                errors++; $display("FAIL b2b_order[%0d]: got %b expected %b", i, got[i], N_REQ'(1 << w));
            end
            rr_last = w;
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle_timeout: got busy expected idle"); end
        checks++; if (min_gap < CLK_DIV) begin errors++; $display("FAIL b2b_gap: got %0d expected >= %0d", min_gap, CLK_DIV); end
        checks++; if (multi_cs != 0) begin errors++; $display("FAIL b2b_onehot_cs: got %0d expected 0", multi_cs); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 6; t++) begin
            logic [N_REQ-1:0] rv;
            logic [DW-1:0]    m, wd;
            int w, len, base_r, base_cs;
            bit ok;
            rv = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                wdata[i*DW +: DW]    = $urandom;
                bitCount[i*BW +: BW] = BW'($urandom_range(0, 40));
            end
            w   = model_rr(rv, rr_last);
            len = model_len(int'(bitCount[w*BW +: BW]));
            wd  = wdata[w*DW +: DW];
            m   = model_mask(len);
            slave_word = $urandom;
            slave_len  = len;
            base_r = clk_rises; base_cs = cs_low;
            launch(rv, 1'b0);
            checks++; if (grant !== N_REQ'(1 << w)) begin errors++; $display("FAIL rand_grant[%0d]: got %b expected %b", t, grant, N_REQ'(1 << w)); end
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_done_timeout[%0d]: got none expected done", t); end
            checks++; if ((sdi_bits[DW-1:0] & m) !== (wd & m)) begin errors++; $display("FAIL rand_sdi[%0d]: got %h expected %h", t, sdi_bits[DW-1:0] & m, wd & m); end
            checks++; if (rdata !== (slave_word & m)) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", t, rdata, slave_word & m); end
            checks++; if (clk_rises - base_r !== len) begin errors++; $display("FAIL rand_sclk[%0d]: got %0d expected %0d", t, clk_rises - base_r, len); end
            checks++; if (cs_low - base_cs !== CLK_DIV * (2 * len + 2)) begin errors++; $display("FAIL rand_cs_low[%0d]: got %0d expected %0d", t, cs_low - base_cs, CLK_DIV * (2 * len + 2)); end
            wait_idle(ok);
            rr_last = w;
        end
    endtask

    task automatic test_clamp;
        logic [N_REQ-1:0] rv;
        int base_r, base_cs;
        bit ok;
        bitCount[2*BW +: BW] = 6'd0;
        bitCount[3*BW +: BW] = 6'd40;
        for (int s = 2; s <= 3; s++) begin
            rv = N_REQ'(1 << s);
            slave_len = DW;
            base_r = clk_rises; base_cs = cs_low;
            launch(rv, 1'b0);
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("FAIL clamp_done_timeout[%0d]: got none expected done", s); end
            checks++; if (clk_rises - base_r !== DW) begin errors++; $display("FAIL clamp_sclk[%0d]: got %0d expected %0d", s, clk_rises - base_r, DW); end
            checks++; if (cs_low - base_cs !== CLK_DIV * (2 * DW + 2)) begin errors++; $display("FAIL clamp_cs_low[%0d]: got %0d expected %0d", s, cs_low - base_cs, CLK_DIV * (2 * DW + 2)); end
            wait_idle(ok);
            rr_last = s;
        end
    endtask

    task automatic test_drop;
        int base_r, base_d;
        bit ok;
        bitCount[1*BW +: BW] = 6'd8;
        slave_len = 8;
        base_r = clk_rises; base_d = done_cnt;
        launch(4'b0010, 1'b1);
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_grant: got %b expected 0010", grant); end
        for (int c = 0; c < 500 && clk_rises - base_r < 3; c++) @(negedge sysClk);
        req = '0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_done_timeout: got none expected done"); end
        checks++; if (clk_rises - base_r !== 8) begin errors++; $display("FAIL drop_sclk: got %0d expected 8", clk_rises - base_r); end
        wait_idle(ok);
        repeat (20) @(negedge sysClk);
        checks++; if (busy !== 1'b0 || grant !== '0) begin errors++; $display("FAIL drop_no_restart: got busy=%b grant=%b expected 0 0000", busy, grant); end
        checks++; if (done_cnt - base_d !== 1) begin errors++; $display("FAIL drop_done_pulses: got %0d expected 1", done_cnt - base_d); end
        rr_last = 1;
    endtask

    task automatic test_reset_mid;
        int base_r;
        bit ok;
        apply_reset;
        wdata[0*DW +: DW]    = $urandom;
        bitCount[0*BW +: BW] = 6'd24;
        slave_len = 24;
        base_r = clk_rises;
        launch(4'b0001, 1'b0);
        for (int c = 0; c < 500 && clk_rises - base_r < 5; c++) @(negedge sysClk);
        @(posedge sysClk);
        #2;
        sysReset_n = 1'b0;
        #1;
        checks++; if (spiCsb !== '1 || spiClk !== 1'b0 || spiSdi !== 1'b0) begin errors++; $display("FAIL midrst_spi: got csb=%b sclk=%b sdi=%b expected 1111 0 0", spiCsb, spiClk, spiSdi); end
        checks++; if (grant !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctl: got grant=%b busy=%b done=%b expected 0000 0 0", grant, busy, done); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", rdata); end
        @(negedge sysClk);
        sysReset_n = 1'b1;
        rr_last    = -1;
        bitCount[2*BW +: BW] = 6'd8;
        slave_word = 32'h5A;
        slave_len  = 8;
        launch(4'b0100, 1'b0);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL midrst_first_grant: got %b expected 0100", grant); end
        wait_done(ok);
        checks++; if (!ok || rdata !== 32'h5A) begin errors++; $display("FAIL midrst_rdata_after: got %h expected 0000005a", rdata); end
        wait_idle(ok);
        rr_last = 2;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_random;
        test_clamp;
        test_drop;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
